// File: rtl/serdes_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serdes_host : host-side byte serdes driver for the CLA adder pin link.
// Optional rsp_err self-check via `define SERDES_HOST_SELFCHECK_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module serdes_host #(
    parameter int WIDTH      = 16,
    parameter int RESULT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z,
`ifdef SERDES_HOST_SELFCHECK_EN
    output logic             rsp_err,
`endif
    output logic [7:0]       pin_data_out,
    output logic             pin_byte_valid,
    output logic             pin_start_calc,
    output logic             pin_output_result,
    input  logic [7:0]       pin_data_in
);

    localparam int c_nb = WIDTH / 8;
    localparam int c_cw = (c_nb > 16) ? $clog2(c_nb) : 4;
    localparam logic [c_cw-1:0] c_nb_last  = c_cw'(c_nb - 1);
    localparam logic [c_cw-1:0] c_lat_last = c_cw'((RESULT_LAT > 0) ? RESULT_LAT - 1 : 0);

    generate
        if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
            $error("serdes_host: WIDTH must be a multiple of 8 and at least 8");
        end
        if (RESULT_LAT < 0 || RESULT_LAT > 15) begin : g_bad_lat
            $error("serdes_host: RESULT_LAT must be in 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_A  = 3'd1,
        SEND_B  = 3'd2,
        START   = 3'd3,
        WAIT    = 3'd4,
        COLLECT = 3'd5,
        RESP    = 3'd6
    } state_e;

    state_e             state_q, state_d;
    logic [c_cw-1:0]    cnt_q, cnt_d;
    logic [2*WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   rsp_z_q, rsp_z_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [7:0]         pin_data_out_q, pin_data_out_d;
    logic               pin_byte_valid_q, pin_byte_valid_d;
    logic               pin_start_calc_q, pin_start_calc_d;
    logic               pin_output_result_q, pin_output_result_d;
    logic               accept;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            cnt_q               <= '0;
            sh_q                <= '0;
            res_q               <= '0;
            rsp_z_q             <= '0;
            req_ready_q         <= 1'b0;
            rsp_valid_q         <= 1'b0;
            pin_data_out_q      <= 8'h00;
            pin_byte_valid_q    <= 1'b0;
            pin_start_calc_q    <= 1'b0;
            pin_output_result_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            cnt_q               <= cnt_d;
            sh_q                <= sh_d;
            res_q               <= res_d;
            rsp_z_q             <= rsp_z_d;
            req_ready_q         <= req_ready_d;
            rsp_valid_q         <= rsp_valid_d;
            pin_data_out_q      <= pin_data_out_d;
            pin_byte_valid_q    <= pin_byte_valid_d;
            pin_start_calc_q    <= pin_start_calc_d;
            pin_output_result_q <= pin_output_result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        res_d   = res_q;
        rsp_z_d = rsp_z_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = {op_b, op_a};
                    cnt_d   = '0;
                    state_d = SEND_A;
                end
            end
            SEND_A, SEND_B: begin
                sh_d = sh_q >> 8;
                if (cnt_q == c_nb_last) begin
                    cnt_d   = '0;
                    state_d = (state_q == SEND_A) ? SEND_B : START;
                end else begin
                    cnt_d = cnt_q + c_cw'(1);
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = (RESULT_LAT == 0) ? COLLECT : WAIT;
            end
            WAIT: begin
                if (cnt_q == c_lat_last) begin
                    cnt_d   = '0;
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q + c_cw'(1);
                end
            end
            COLLECT: begin
                // Bytes arrive LSB first, so shift in from the top.
                res_d = res_q >> 8;
                res_d[WIDTH-1 -: 8] = pin_data_in;
                if (cnt_q == c_nb_last) begin
                    cnt_d   = '0;
                    rsp_z_d = res_d;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + c_cw'(1);
                end
            end
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered: they describe the state being entered.
        req_ready_d         = (state_d == IDLE);
        pin_byte_valid_d    = (state_d == SEND_A) || (state_d == SEND_B);
        pin_data_out_d      = pin_byte_valid_d ? sh_d[7:0] : 8'h00;
        pin_start_calc_d    = (state_d == START);
        pin_output_result_d = (state_d == WAIT) || (state_d == COLLECT);
        rsp_valid_d         = (state_d == RESP);
    end

`ifdef SERDES_HOST_SELFCHECK_EN
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             rsp_err_q, rsp_err_d;

    always_comb begin
        sum_d     = accept ? (op_a + op_b) : sum_q;
        rsp_err_d = (state_d == RESP) && (rsp_z_d != sum_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            sum_q     <= sum_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign rsp_err = rsp_err_q;
`endif

    assign req_ready         = req_ready_q;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_z             = rsp_z_q;
    assign pin_data_out      = pin_data_out_q;
    assign pin_byte_valid    = pin_byte_valid_q;
    assign pin_start_calc    = pin_start_calc_q;
    assign pin_output_result = pin_output_result_q;

endmodule
`default_nettype wire

// File: tb/tb_serdes_host.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serdes_host : directed bench for serdes_host (16b/LAT1 and 32b/LAT0)
// with a behavioural adder device on the pin side.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_serdes_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        req_valid16, req_ready16, rsp_valid16, rsp_ready16;
    logic [15:0] op_a16, op_b16, rsp_z16;
    logic [7:0]  pdo16, pdi16;
    logic        pbv16, pst16, por16;

    logic        req_valid32, req_ready32, rsp_valid32, rsp_ready32;
    logic [31:0] op_a32, op_b32, rsp_z32;
    logic [7:0]  pdo32, pdi32;
    logic        pbv32, pst32, por32;
`ifdef SERDES_HOST_SELFCHECK_EN
    logic        err16, err32;
`endif

    serdes_host #(.WIDTH(16), .RESULT_LAT(1)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid16), .req_ready(req_ready16),
        .op_a(op_a16), .op_b(op_b16),
        .rsp_valid(rsp_valid16), .rsp_ready(rsp_ready16), .rsp_z(rsp_z16),
`ifdef SERDES_HOST_SELFCHECK_EN
        .rsp_err(err16),
`endif
        .pin_data_out(pdo16), .pin_byte_valid(pbv16), .pin_start_calc(pst16),
        .pin_output_result(por16), .pin_data_in(pdi16)
    );

    serdes_host #(.WIDTH(32), .RESULT_LAT(0)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid32), .req_ready(req_ready32),
        .op_a(op_a32), .op_b(op_b32),
        .rsp_valid(rsp_valid32), .rsp_ready(rsp_ready32), .rsp_z(rsp_z32),
`ifdef SERDES_HOST_SELFCHECK_EN
        .rsp_err(err32),
`endif
        .pin_data_out(pdo32), .pin_byte_valid(pbv32), .pin_start_calc(pst32),
        .pin_output_result(por32), .pin_data_in(pdi32)
    );

    // Device models: capture operand bytes, answer with a+b after the latency.
    logic [31:0] cap16 = '0;
    logic [63:0] cap32 = '0;
    int          ocnt16 = 0, ocnt32 = 0;
    logic        fault = 1'b0;
    logic [15:0] sum16;
    logic [31:0] sum32;

    always @(posedge clk) begin
        if (pbv16) cap16 <= {pdo16, cap16[31:8]};
        if (pbv32) cap32 <= {pdo32, cap32[63:8]};
        ocnt16 <= por16 ? ocnt16 + 1 : 0;
        ocnt32 <= por32 ? ocnt32 + 1 : 0;
    end

    assign sum16 = cap16[15:0] + cap16[31:16] + {15'd0, fault};
    assign sum32 = cap32[31:0] + cap32[63:32];
    assign pdi16 = (por16 && ocnt16 >= 1) ? 8'(sum16 >> (8 * (ocnt16 - 1))) : 8'h00;
    assign pdi32 = por32 ? 8'(sum32 >> (8 * ocnt32)) : 8'h00;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle expectations after accept (bit/element i = cycle i after accept edge).
    logic [8:0]  e_bv16 = 9'b0_0000_1111;
    logic [8:0]  e_st16 = 9'b0_0001_0000;
    logic [8:0]  e_or16 = 9'b0_1110_0000;
    logic [8:0]  e_rv16 = 9'b1_0000_0000;
    logic [7:0]  e_do16 [0:8] = '{8'h34, 8'h12, 8'h0F, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [13:0] e_bv32 = 14'b00_0000_1111_1111;
    logic [13:0] e_st32 = 14'b00_0001_0000_0000;
    logic [13:0] e_or32 = 14'b01_1110_0000_0000;
    logic [13:0] e_rv32 = 14'b10_0000_0000_0000;
    logic [7:0]  e_do32 [0:13] = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h80,
                                   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    int lat;
    int seen;

    initial begin
        rst_n = 1'b0;
        req_valid16 = 1'b0; rsp_ready16 = 1'b0; op_a16 = '0; op_b16 = '0;
        req_valid32 = 1'b0; rsp_ready32 = 1'b1; op_a32 = '0; op_b32 = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready16, 0);
        check("rst_rsp_valid", rsp_valid16, 0);
        check("rst_rsp_z", rsp_z16, 0);
        check("rst_pins", {pdo16, pbv16, pst16, por16}, 0);
        check("rst_req_ready32", req_ready32, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", req_ready16, 1);
        check("rel_req_ready32", req_ready32, 1);

        // Basic transaction, operands changed right after accept.
        op_a16 = 16'h1234; op_b16 = 16'h0F0F; req_valid16 = 1'b1;
        @(negedge clk);
        req_valid16 = 1'b0; op_a16 = 16'hDEAD; op_b16 = 16'hBEEF;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("t1_bv[%0d]", i), pbv16, e_bv16[i]);
            check($sformatf("t1_do[%0d]", i), pdo16, e_do16[i]);
            check($sformatf("t1_st[%0d]", i), pst16, e_st16[i]);
            check($sformatf("t1_or[%0d]", i), por16, e_or16[i]);
            check($sformatf("t1_rv[%0d]", i), rsp_valid16, e_rv16[i]);
        end
        check("t1_rsp_z", rsp_z16, 16'h2143);
        check("t1_req_ready", req_ready16, 0);
`ifdef SERDES_HOST_SELFCHECK_EN
        check("t1_err", err16, 0);
`endif

        // Stall in RESP with a new request pending.
        op_a16 = 16'hFFFF; op_b16 = 16'h0001; req_valid16 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("stall_rv[%0d]", i), rsp_valid16, 1);
            check($sformatf("stall_z[%0d]", i), rsp_z16, 16'h2143);
            check($sformatf("stall_rr[%0d]", i), req_ready16, 0);
            check($sformatf("stall_pins[%0d]", i), {pdo16, pbv16, pst16, por16}, 0);
        end
        rsp_ready16 = 1'b1;
        @(negedge clk);
        check("hs_rv", rsp_valid16, 0);
        check("hs_rr", req_ready16, 1);
        check("hs_bv", pbv16, 0);
        check("hs_z_hold", rsp_z16, 16'h2143);
        @(negedge clk);
        req_valid16 = 1'b0;
        check("acc2_bv", pbv16, 1);
        check("acc2_do", pdo16, 8'hFF);
        check("acc2_rr", req_ready16, 0);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid16) begin
                lat = k;
                break;
            end
        end
        check("wrap_latency", lat, 8);
        check("wrap_rsp_z", rsp_z16, 16'h0000);
`ifdef SERDES_HOST_SELFCHECK_EN
        check("wrap_err", err16, 0);
`endif
        @(negedge clk);
        check("wrap_done_rv", rsp_valid16, 0);
        check("wrap_done_rr", req_ready16, 1);

        // Reset during SEND_B drops the transaction.
        op_a16 = 16'hAAAA; op_b16 = 16'h5555; req_valid16 = 1'b1;
        @(negedge clk);
        req_valid16 = 1'b0;
        repeat (2) @(negedge clk);
        check("mr_in_sendb_bv", pbv16, 1);
        check("mr_in_sendb_do", pdo16, 8'h55);
        #2 rst_n = 1'b0;
        #1;
        check("mr_rr", req_ready16, 0);
        check("mr_rv", rsp_valid16, 0);
        check("mr_z", rsp_z16, 0);
        check("mr_pins", {pdo16, pbv16, pst16, por16}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_rel_rr", req_ready16, 1);
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            if (rsp_valid16 || por16 || pbv16) seen++;
        end
        check("mr_no_rsp", seen, 0);

        // Faulty device result.
        fault = 1'b1;
        op_a16 = 16'h0001; op_b16 = 16'h0002; req_valid16 = 1'b1;
        @(negedge clk);
        req_valid16 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid16) begin
                lat = k;
                break;
            end
        end
        check("fault_latency", lat, 8);
        check("fault_rsp_z", rsp_z16, 16'h0004);
`ifdef SERDES_HOST_SELFCHECK_EN
        check("fault_err", err16, 1);
`endif
        @(negedge clk);
        check("fault_done_rv", rsp_valid16, 0);
`ifdef SERDES_HOST_SELFCHECK_EN
        check("fault_err_clr", err16, 0);
`endif
        fault = 1'b0;

        // 32-bit instance, zero result latency.
        op_a32 = 32'h8000_0000; op_b32 = 32'h8000_0001; req_valid32 = 1'b1;
        @(negedge clk);
        req_valid32 = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("w32_bv[%0d]", i), pbv32, e_bv32[i]);
            check($sformatf("w32_do[%0d]", i), pdo32, e_do32[i]);
            check($sformatf("w32_st[%0d]", i), pst32, e_st32[i]);
            check($sformatf("w32_or[%0d]", i), por32, e_or32[i]);
            check($sformatf("w32_rv[%0d]", i), rsp_valid32, e_rv32[i]);
        end
        check("w32_rsp_z", rsp_z32, 32'h0000_0001);
`ifdef SERDES_HOST_SELFCHECK_EN
        check("w32_err", err32, 0);
`endif
        @(negedge clk);
        check("w32_done_rv", rsp_valid32, 0);
        check("w32_done_rr", req_ready32, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serdes_host.md
Name: serdes_host

Overview:
- Host-side counterpart of the byte-wide operand/result serdes link in front of the CLA adder.
- Accepts one WIDTH-bit operand pair over a valid/ready request port.
- Serializes both operands onto the 8-bit pin bus, strobes start_calc, then drives output_result and gathers the result bytes back into a WIDTH-bit response.
- Used as the bench/FPGA-side driver of the chip pins, and as the loopback partner in top-level simulation.

Parameters:
- WIDTH, 16: operand/result width in bits; must be a multiple of 8 and at least 8 (elaboration error otherwise).
- RESULT_LAT, 1: cycles from output_result rising to the first valid result byte on pin_data_in; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  operand pair offered
- req_ready  out  1  host idle, request accepted when req_valid&&req_ready
- op_a  in  WIDTH  operand a, captured on accept
- op_b  in  WIDTH  operand b, captured on accept
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_z  out  WIDTH  assembled result
- pin_data_out  out  8  operand byte toward device inputs
- pin_byte_valid  out  1  pin_data_out holds an operand byte this cycle
- pin_start_calc  out  1  one-cycle start pulse
- pin_output_result  out  1  held high while result bytes are read
- pin_data_in  in  8  result byte from device outputs

Behaviour:
- NB = WIDTH/8. All outputs are registered.
- Reset values: req_ready=0 during reset and 1 in the first cycle after release. rsp_valid, rsp_z, pin_data_out, pin_byte_valid, pin_start_calc and pin_output_result are all 0.
- FSM states: IDLE, SEND_A, SEND_B, START, WAIT, COLLECT, RESP.
- IDLE:
  - req_ready=1.
  - On accept: latch op_a/op_b into shift registers, req_ready->0, go to SEND_A.
- SEND_A: NB cycles.
  - Each cycle: pin_byte_valid=1, pin_data_out = next byte of a, least-significant byte first.
  - Byte counter wraps at NB-1, then go to SEND_B.
- SEND_B: same as SEND_A for b, LSB first, then go to START.
- Operand bytes go out back-to-back, with no gap between a and b; pin_byte_valid drops to 0 in START.
- START: pin_start_calc=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - pin_output_result=1 and stays high through COLLECT.
  - Lasts RESULT_LAT cycles; RESULT_LAT=0 skips WAIT entirely.
- COLLECT:
  - NB cycles. Each cycle, pin_data_in is shifted into the result register at byte position [8k+7:8k], k = 0..NB-1 (LSB first).
  - Go to RESP after the last byte; pin_output_result drops to 0 on entering RESP.
- RESP:
  - rsp_valid=1, rsp_z stable.
  - On rsp_valid&&rsp_ready: rsp_valid->0, go to IDLE. req_ready=1 again the cycle after the handshake.
- rsp_z holds its last value until the next COLLECT completes.
- Latency, accept to rsp_valid: 2*NB + 1 + RESULT_LAT + NB cycles. For WIDTH=16, RESULT_LAT=1: 8 cycles.
- rsp_ready held low: the block stalls in RESP indefinitely; pin outputs stay at 0.
- A request is never accepted while rsp_valid=1. There is no pipelining and at most one transaction is in flight.
- op_a/op_b changes after accept have no effect.
- rst_n asserted mid-transaction: all state and outputs clear immediately (asynchronous). The in-flight transaction is dropped; no partial response is issued.

Optional Feature:
- Macro: SERDES_HOST_SELFCHECK_EN.
- Defined:
  - Adds output port rsp_err (1 bit, reset 0).
  - In RESP, rsp_err = (rsp_z != (a+b) mod 2^WIDTH), computed from the latched operands.
  - rsp_err is valid only while rsp_valid=1 and clears with it.
- Undefined: the port and the comparison logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=16, RESULT_LAT=1. Request a=0x1234, b=0x0F0F; a device model returns a+b.
  - pin_data_out sequence 34,12,0F,0F with pin_byte_valid=1 for 4 cycles.
  - Then a one-cycle start pulse.
  - rsp_z=0x2143 with rsp_valid on cycle 8 after accept.
- a=0xFFFF, b=0x0001 -> rsp_z=0x0000 (wrap). With SERDES_HOST_SELFCHECK_EN defined, rsp_err=0.
- Hold rsp_ready=0 for 20 cycles after rsp_valid.
  - rsp_valid and rsp_z stay stable; req_ready=0.
  - A second req_valid is not accepted until 1 cycle after the rsp handshake.
- Assert rst_n=0 during SEND_B.
  - All outputs read 0 immediately.
  - After release: req_ready=1 and no rsp_valid is ever emitted for the dropped request.
- RESULT_LAT=0 and WIDTH=32, a=0x80000000, b=0x80000001.
  - 8 operand bytes are sent.
  - Result is sampled in the cycle after start; rsp_z=0x00000001.
- SERDES_HOST_SELFCHECK_EN defined, device model returns a faulty byte for a=0x0001, b=0x0002 (0x0004 instead of 0x0003) -> rsp_err=1 with rsp_valid.
